load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: lane-select loads with sign/zero extension, and byte/half stores
// done as a read-merge-write. Optional word-index bounds check under macro LSU_RANGE_CHECK_EN.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1028
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        range_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e      state_q, state_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        misalign_q, misalign_d;
  logic        range_err_q, range_err_d;
  logic [31:0] widx_q, widx_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] word_idx;
  logic        misaligned;
  logic        out_of_range;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        rd, wr, st;

  assign word_idx     = {2'b00, req_addr[31:2]};
  assign misaligned   = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign out_of_range = RangeCheck && (word_idx >= MEM_WORDS);

  assign lane_b = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
  assign lane_h = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = mem_rdata;
    merged   = mem_rdata;
    unique case (req_size)
      2'b00: begin
        load_ext = {{24{~req_unsigned & lane_b[7]}}, lane_b};
        merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      end
      2'b01: begin
        load_ext = {{16{~req_unsigned & lane_h[15]}}, lane_h};
        merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_data_d   = ld_data_q;
    ld_valid_d  = 1'b0;
    misalign_d  = 1'b0;
    range_err_d = 1'b0;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    rd          = 1'b0;
    wr          = 1'b0;
    st          = 1'b0;
    mem_addr    = word_idx;
    mem_wdata   = req_wdata;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else if (out_of_range) begin
            range_err_d = 1'b1;
          end else if (!req_write) begin
            rd         = 1'b1;
            ld_valid_d = 1'b1;
            ld_data_d  = load_ext;
          end else if (req_size == 2'b10) begin
            wr = 1'b1;
          end else begin
            // Sub-word store: read the word now, write the merged word next cycle.
            rd      = 1'b1;
            st      = 1'b1;
            widx_d  = word_idx;
            wdata_d = merged;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_addr  = widx_q;
        mem_wdata = wdata_q;
        wr        = 1'b1;
        state_d   = StIdle;
      end
    endcase
  end

  // Reset gates the memory strobes immediately, dropping any pending merged write.
  assign mem_read  = rd & resetN;
  assign mem_write = wr & resetN;
  assign stall     = st & resetN;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= StIdle;
      ld_data_q   <= 32'h0;
      ld_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      range_err_q <= 1'b0;
      widx_q      <= 32'h0;
      wdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      ld_data_q   <= ld_data_d;
      ld_valid_q  <= ld_valid_d;
      misalign_q  <= misalign_d;
      range_err_q <= range_err_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
    end
  end

  assign ld_data   = ld_data_q;
  assign ld_valid  = ld_valid_q;
  assign misalign  = misalign_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit against a byte-array memory model; honours
// LSU_RANGE_CHECK_EN the same way the design does.
module tb_load_store_unit;

  localparam int unsigned MemWords = 1028;
  localparam int unsigned TbWords  = 2048;

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RangeOn = 1'b1;
`else
  localparam bit RangeOn = 1'b0;
`endif

  logic        clk;
  logic        resetN;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misalign;
  logic        range_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(MemWords)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .misalign     (misalign),
    .range_err    (range_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory seen by the DUT.
  logic [31:0] mem [0:TbWords-1];
  assign mem_rdata = (mem_addr < TbWords) ? mem[mem_addr[10:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write && mem_addr < TbWords) mem[mem_addr[10:0]] <= mem_wdata;
  end

  // Reference: plain little-endian byte array.
  logic [7:0]  ref_b [0:TbWords*4-1];
  logic [31:0] last_ld;
  int          n_checks;
  int          n_fails;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  // Issue one request starting #1 after a rising edge; returns #1 after the final edge.
  task automatic do_req(input bit wr, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int          a;
    int          idx;
    bit          mis, oor, ok, sub;
    logic [31:0] exp_ld;
    logic [31:0] exp_w;
    logic [7:0]  b;
    logic [15:0] h;
    a      = int'(addr);
    idx    = a / 4;
    mis    = (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
    oor    = !mis && RangeOn && (idx >= int'(MemWords));
    ok     = !mis && !oor;
    sub    = ok && wr && (size != 2'd2);
    exp_ld = 32'h0;
    exp_w  = 32'h0;
    if (ok && !wr) begin
      b = ref_b[a];
      h = {ref_b[a+1], ref_b[a]};
      case (size)
        2'd0:    exp_ld = uns ? 32'(b) : 32'($signed(b));
        2'd1:    exp_ld = uns ? 32'(h) : 32'($signed(h));
        default: exp_ld = ref_word(idx);
      endcase
    end
    if (ok && wr) begin
      ref_b[a] = wd[7:0];
      if (size != 2'd0) ref_b[a+1] = wd[15:8];
      if (size == 2'd2) begin
        ref_b[a+2] = wd[23:16];
        ref_b[a+3] = wd[31:24];
      end
      exp_w = ref_word(idx);
    end

    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(negedge clk);
    check_eq("req_mem_read", 32'(mem_read), 32'(ok && (!wr || sub)));
    check_eq("req_mem_write", 32'(mem_write), 32'(ok && wr && !sub));
    check_eq("req_stall", 32'(stall), 32'(sub));
    check_eq("req_mem_addr", mem_addr, addr >> 2);
    if (ok && wr && !sub) check_eq("sw_wdata", mem_wdata, exp_w);
    @(posedge clk);
    #1;
    if (sub) begin
      @(negedge clk);
      check_eq("wr_mem_write", 32'(mem_write), 32'd1);
      check_eq("wr_mem_read", 32'(mem_read), 32'd0);
      check_eq("wr_stall", 32'(stall), 32'd0);
      check_eq("wr_mem_addr", mem_addr, 32'(idx));
      check_eq("wr_merged", mem_wdata, exp_w);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check_eq("ld_valid", 32'(ld_valid), 32'(ok && !wr));
    check_eq("misalign", 32'(misalign), 32'(mis));
    check_eq("range_err", 32'(range_err), 32'(oor));
    if (ok && !wr) last_ld = exp_ld;
    check_eq("ld_data", ld_data, last_ld);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] old1028;
    n_checks     = 0;
    n_fails      = 0;
    last_ld      = 32'h0;
    resetN       = 1'b0;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    for (int i = 0; i < int'(TbWords); i++) begin
      w = $urandom;
      mem[i] = w;
      {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]} = w;
    end

    // Reset with a pending request: strobes gated, registered outputs cleared.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ld_valid", 32'(ld_valid), 32'd0);
    check_eq("rst_ld_data", ld_data, 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_range_err", 32'(range_err), 32'd0);
    @(negedge clk);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    resetN    = 1'b1;

    // Directed cases.
    do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h8070_F0A1);
    do_req(1'b0, 2'd0, 1'b0, 32'h15, 32'h0);
    check_eq("lb_0x15", ld_data, 32'hFFFF_FFF0);
    do_req(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
    check_eq("lhu_0x16", ld_data, 32'h0000_8070);
    do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
    check_eq("lh_0x16", ld_data, 32'hFFFF_8070);
    do_req(1'b1, 2'd0, 1'b0, 32'h17, 32'h0000_00EE);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    check_eq("sb_merge", ld_data, 32'hEE70_F0A1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0A, 32'h0);
    old1028 = mem[1028];
    do_req(1'b1, 2'd2, 1'b0, 32'h1010, 32'hCAFE_0001);
    check_eq("sw_1028", mem[1028], RangeOn ? old1028 : 32'hCAFE_0001);

    // Reset during the write half of a halfword store drops the write.
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd1;
    req_addr  = 32'h20;
    req_wdata = 32'h0000_1234;
    @(negedge clk);
    check_eq("sh_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    resetN = 1'b0;
    @(negedge clk);
    check_eq("rstw_mem_write", 32'(mem_write), 32'd0);
    check_eq("rstw_mem_read", 32'(mem_read), 32'd0);
    check_eq("rstw_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    resetN    = 1'b1;
    last_ld   = 32'h0;
    check_eq("rstw_ld_data", ld_data, 32'd0);
    check_eq("rstw_ld_valid", 32'(ld_valid), 32'd0);
    check_eq("rstw_misalign", 32'(misalign), 32'd0);
    check_eq("rstw_range_err", 32'(range_err), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    // Random traffic with occasional idle cycles.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check_eq("idle_read", 32'(mem_read), 32'd0);
        check_eq("idle_write", 32'(mem_write), 32'd0);
        check_eq("idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check_eq("idle_ld_valid", 32'(ld_valid), 32'd0);
        check_eq("idle_ld_data", ld_data, last_ld);
      end
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1100) * 4 + $urandom_range(0, 3)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
